// File: rtl/jtcop_snd_pkg.sv
// Shared constants for the sound mixer: sequencer state encoding, 4.4 unity gain
// and an elaboration-time ceil(log2) helper.
package jtcop_snd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] GAIN_UNITY = 8'h10;

  // Never returns less than 1 so it can size vectors safely.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/jtcop_sndmix_sat.sv
// Output stage of the mixer: clamps the scaled accumulator to WOUT bits and
// keeps the clip indicator alive for PEAK_HOLD samples after the last clip.
module jtcop_sndmix_sat
  import jtcop_snd_pkg::*;
#(
  parameter int SW        = 22,
  parameter int WOUT      = 16,
  parameter int PEAK_HOLD = 1024
)(
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   vld,
  input  logic signed [SW-1:0]   acc_sh,
  output logic signed [WOUT-1:0] mixed,
  output logic                   sample,
  output logic                   peak
);

  localparam int HW = clog2(PEAK_HOLD + 1);
  localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (WOUT - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  // Returns {clipped, clamped value}.
  function automatic logic [WOUT:0] sat_fn(input logic signed [SW-1:0] v);
    if (v > MAXV)      return {1'b1, MAXV[WOUT-1:0]};
    else if (v < MINV) return {1'b1, MINV[WOUT-1:0]};
    else               return {1'b0, v[WOUT-1:0]};
  endfunction

  logic                   vld_p0_q, vld_p0_d;
  logic signed [SW-1:0]   val_p0_q, val_p0_d;
  logic signed [WOUT-1:0] mixed_q, mixed_d;
  logic                   sample_q, sample_d;
  logic                   peak_q, peak_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   clip;
  logic [WOUT-1:0]        sat_val;

  always_comb begin
    vld_p0_d = vld;
    val_p0_d = vld ? acc_sh : val_p0_q;
    {clip, sat_val} = sat_fn(val_p0_q);
    mixed_d  = mixed_q;
    peak_d   = peak_q;
    hold_d   = hold_q;
    sample_d = vld_p0_q;
    if (vld_p0_q) begin
      mixed_d = sat_val;
      if (clip) begin
        peak_d = 1'b1;
        hold_d = HW'(PEAK_HOLD);
      end else begin
        // Peak stays up while any hold count remains, then drops.
        peak_d = (hold_q != '0);
        if (hold_q != '0) hold_d = hold_q - 1'b1;
      end
    end
  end

  // Stage p0: scaled accumulator captured; next edge: clamped result published.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      mixed_q  <= '0;
      sample_q <= 1'b0;
      peak_q   <= 1'b0;
      hold_q   <= '0;
    end else begin
      vld_p0_q <= vld_p0_d;
      mixed_q  <= mixed_d;
      sample_q <= sample_d;
      peak_q   <= peak_d;
      hold_q   <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    val_p0_q <= val_p0_d;
  end

  assign mixed  = mixed_q;
  assign sample = sample_q;
  assign peak   = peak_q;

endmodule

// File: rtl/jtcop_sndmix.sv
// Multi-channel sound mixer: one shared multiplier walks the channels after each
// sample strobe, accumulating sample*gain (4.4) and handing the sum to the clamp.
module jtcop_sndmix
  import jtcop_snd_pkg::*;
#(
  parameter int               NCH       = 4,
  parameter int               W         = 16,
  parameter int               WOUT      = 16,
  parameter logic [NCH*8-1:0] GAIN_RST  = {NCH{GAIN_UNITY}},
  parameter int               PEAK_HOLD = 1024
)(
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   cen,
  input  logic [NCH*W-1:0]       ch_in,
  input  logic [NCH-1:0]         ch_en,
  input  logic                   gain_we,
  input  logic [2:0]             gain_sel,
  input  logic [7:0]             gain_din,
  output logic signed [WOUT-1:0] mixed,
  output logic                   sample,
  output logic                   peak,
  output logic                   overrun
);

  localparam int XW    = (W < WOUT) ? WOUT : W;
  localparam int IW    = clog2(NCH);
  localparam int ACC_W = XW + 8 + IW;
  localparam int PW    = XW + 9;

  // Narrow inputs are left-aligned so full scale matches the output range.
  function automatic logic signed [XW-1:0] align(input logic [W-1:0] x);
    return XW'($signed(x)) <<< (XW - W);
  endfunction

  logic [1:0]              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]              gain_q [NCH];
  logic [7:0]              gain_d [NCH];
  logic signed [XW-1:0]    smp_q [NCH];
  logic signed [XW-1:0]    smp_d [NCH];
  logic [7:0]              sgain_q [NCH];
  logic [7:0]              sgain_d [NCH];
  logic                    overrun_q, overrun_d;
  logic                    done;
  logic signed [PW-1:0]    prod;

  assign prod = PW'(smp_q[idx_q]) * PW'($signed({1'b0, sgain_q[idx_q]}));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    smp_d     = smp_q;
    sgain_d   = sgain_q;
    gain_d    = gain_q;
    done      = 1'b0;
    overrun_d = cen && (state_q != ST_IDLE);
    for (int i = 0; i < NCH; i++) begin
      if (gain_we && gain_sel == 3'(i)) gain_d[i] = gain_din;
    end
    case (state_q)
      ST_IDLE: begin
        if (cen) begin
          // Shadows see the pre-write gains, so a same-cycle write waits a sample.
          for (int i = 0; i < NCH; i++) begin
            smp_d[i]   = ch_en[i] ? align(ch_in[i*W +: W]) : '0;
            sgain_d[i] = gain_q[i];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (idx_q == IW'(NCH - 1)) state_d = ST_DONE;
        else                       idx_d   = idx_q + 1'b1;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NCH; i++) gain_q[i] <= GAIN_RST[i*8 +: 8];
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      overrun_q <= overrun_d;
      gain_q    <= gain_d;
    end
  end

  always_ff @(posedge clk) begin
    smp_q   <= smp_d;
    sgain_q <= sgain_d;
  end

  jtcop_sndmix_sat #(
    .SW        (ACC_W - 4),
    .WOUT      (WOUT),
    .PEAK_HOLD (PEAK_HOLD)
  ) u_sat (
    .rst    (rst),
    .clk    (clk),
    .vld    (done),
    .acc_sh (acc_q[ACC_W-1:4]),
    .mixed  (mixed),
    .sample (sample),
    .peak   (peak)
  );

  assign overrun = overrun_q;

endmodule

// File: tb/tb_jtcop_sndmix.sv
// Directed bench for jtcop_sndmix (NCH=4, W=WOUT=16, unity reset gains).
module tb_jtcop_sndmix;

  logic               rst, clk, cen;
  logic [63:0]        ch_in;
  logic [3:0]         ch_en;
  logic               gain_we;
  logic [2:0]         gain_sel;
  logic [7:0]         gain_din;
  logic signed [15:0] mixed;
  logic               sample, peak, overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  jtcop_sndmix dut (
    .rst      (rst),
    .clk      (clk),
    .cen      (cen),
    .ch_in    (ch_in),
    .ch_en    (ch_en),
    .gain_we  (gain_we),
    .gain_sel (gain_sel),
    .gain_din (gain_din),
    .mixed    (mixed),
    .sample   (sample),
    .peak     (peak),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ch(input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] a2, input logic [15:0] a3);
    ch_in = {a3, a2, a1, a0};
  endtask

  task automatic write_gain(input logic [2:0] sel, input logic [7:0] din);
    @(negedge clk);
    gain_we = 1'b1; gain_sel = sel; gain_din = din;
    @(negedge clk);
    gain_we = 1'b0;
  endtask

  // kind: 0 none, 1 gain write at edge act, 2 extra cen at edge act, 3 gain write with cen.
  task automatic run_sample(input int act, input int kind,
                            output logic [15:0] res, output int lat,
                            output int n_smp, output int n_ovr, output int ovr_edge);
    @(negedge clk);
    cen = 1'b1;
    gain_we = (kind == 3);
    @(posedge clk);
    lat = 0; res = '0; n_smp = 0; n_ovr = 0; ovr_edge = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      cen = (kind == 2 && i == act);
      gain_we = (kind == 1 && i == act);
      @(posedge clk); #1;
      if (sample) begin
        n_smp++;
        if (lat == 0) begin lat = i; res = mixed; end
      end
      if (overrun) begin
        n_ovr++;
        if (ovr_edge == 0) ovr_edge = i;
      end
    end
    @(negedge clk);
    cen = 1'b0; gain_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cen = 1'b0; gain_we = 1'b0; gain_sel = '0; gain_din = '0;
    ch_en = 4'hF; set_ch(16'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mixed !== 16'sd0) begin n_fail++; $display("FAIL reset_mixed: got %0d want 0", mixed); end
    n_cmp++; if (sample !== 1'b0) begin n_fail++; $display("FAIL reset_sample: got %b want 0", sample); end
    n_cmp++; if (peak !== 1'b0) begin n_fail++; $display("FAIL reset_peak: got %b want 0", peak); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_basic;
    logic [15:0] r; int lat, ns, no, oe;
    ch_in = {16'd100, 16'd200, -16'd50, 16'd0};
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'd250) begin n_fail++; $display("FAIL basic_mixed: got %0d want 250", $signed(r)); end
    n_cmp++; if (lat != 6) begin n_fail++; $display("FAIL basic_latency: got %0d want 6", lat); end
    n_cmp++; if (ns != 1 || no != 0) begin n_fail++; $display("FAIL basic_pulses: samples %0d overruns %0d want 1 0", ns, no); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (mixed !== 16'sd250) begin n_fail++; $display("FAIL basic_hold: got %0d want 250", mixed); end
  endtask

  task automatic test_disable;
    logic [15:0] r; int lat, ns, no, oe;
    ch_en = 4'b0001;
    set_ch(-16'sd300, 16'd1000, 16'd1000, 16'd1000);
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'hFED4) begin n_fail++; $display("FAIL disable_mixed: got %0d want -300", $signed(r)); end
    ch_en = 4'hF;
  endtask

  task automatic test_fractional;
    logic [15:0] r; int lat, ns, no, oe;
    write_gain(3'd0, 8'h18);
    set_ch(-16'sd7, 16'd0, 16'd0, 16'd0);
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'hFFF5) begin n_fail++; $display("FAIL frac_neg: got %0d want -11", $signed(r)); end
    set_ch(16'd7, 16'd0, 16'd0, 16'd0);
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'd10) begin n_fail++; $display("FAIL frac_pos: got %0d want 10", $signed(r)); end
    write_gain(3'd0, 8'h10);
  endtask

  task automatic test_gain_timing;
    logic [15:0] r; int lat, ns, no, oe;
    set_ch(16'd10, 16'd100, 16'd0, 16'd0);
    gain_sel = 3'd1; gain_din = 8'h20;
    run_sample(1, 1, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'd110) begin n_fail++; $display("FAIL gain_mac_a: got %0d want 110", $signed(r)); end
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'd210) begin n_fail++; $display("FAIL gain_mac_b: got %0d want 210", $signed(r)); end
    gain_sel = 3'd0; gain_din = 8'h30;
    run_sample(0, 3, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'd210) begin n_fail++; $display("FAIL gain_same_clk: got %0d want 210", $signed(r)); end
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'd230) begin n_fail++; $display("FAIL gain_after: got %0d want 230", $signed(r)); end
    write_gain(3'd4, 8'h00);
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'd230) begin n_fail++; $display("FAIL gain_sel_oob: got %0d want 230", $signed(r)); end
  endtask

  task automatic test_overrun;
    logic [15:0] r; int lat, ns, no, oe;
    set_ch(16'd10, 16'd100, 16'd0, 16'd0);
    run_sample(2, 2, r, lat, ns, no, oe);
    n_cmp++; if (no != 1 || oe != 2) begin n_fail++; $display("FAIL overrun_pulse: count %0d at edge %0d want 1 at 2", no, oe); end
    n_cmp++; if (ns != 1) begin n_fail++; $display("FAIL overrun_samples: got %0d want 1", ns); end
    n_cmp++; if (r !== 16'd230 || lat != 6) begin n_fail++; $display("FAIL overrun_mixed: got %0d lat %0d want 230 lat 6", $signed(r), lat); end
  endtask

  task automatic test_reset_mid_mac;
    logic [15:0] r; int lat, ns, no, oe, seen;
    seen = 0;
    @(negedge clk); cen = 1'b1;
    @(posedge clk);
    @(negedge clk); cen = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (sample) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL rstmac_sample: got %0d pulses want 0", seen); end
    n_cmp++; if (mixed !== 16'sd0 || peak !== 1'b0) begin n_fail++; $display("FAIL rstmac_out: mixed %0d peak %b want 0 0", mixed, peak); end
    set_ch(16'd10, 16'd100, 16'd0, 16'd0);
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'd110 || lat != 6) begin n_fail++; $display("FAIL rstmac_gains: got %0d lat %0d want 110 lat 6", $signed(r), lat); end
  endtask

  task automatic test_saturation;
    logic [15:0] r; int lat, ns, no, oe, early;
    set_ch(16'h7FFF, 16'd0, 16'd0, 16'd0);
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'h7FFF || peak !== 1'b0) begin n_fail++; $display("FAIL sat_max_exact: got %h peak %b want 7fff 0", r, peak); end
    set_ch(16'h8000, 16'd0, 16'd0, 16'd0);
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'h8000 || peak !== 1'b0) begin n_fail++; $display("FAIL sat_min_exact: got %h peak %b want 8000 0", r, peak); end
    set_ch(16'h7000, 16'h7000, 16'd0, 16'd0);
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'h7FFF || peak !== 1'b1) begin n_fail++; $display("FAIL sat_pos_clip: got %h peak %b want 7fff 1", r, peak); end
    set_ch(16'h9000, 16'h9000, 16'd0, 16'd0);
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (r !== 16'h8000 || peak !== 1'b1) begin n_fail++; $display("FAIL sat_neg_clip: got %h peak %b want 8000 1", r, peak); end
    set_ch(16'd0, 16'd0, 16'd0, 16'd0);
    early = 0;
    for (int k = 1; k <= 1024; k++) begin
      run_sample(0, 0, r, lat, ns, no, oe);
      if (peak !== 1'b1 || r !== 16'd0) early++;
    end
    n_cmp++; if (early != 0) begin n_fail++; $display("FAIL peak_hold: %0d of 1024 samples lost peak want 0", early); end
    run_sample(0, 0, r, lat, ns, no, oe);
    n_cmp++; if (peak !== 1'b0) begin n_fail++; $display("FAIL peak_release: got %b want 0", peak); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_disable;
    test_fractional;
    test_gain_timing;
    test_overrun;
    test_reset_mid_mac;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jtcop_sndmix.md
JTCOP_SNDMIX -- requirements
Module: jtcop_sndmix

Interface
REQ-001 SHALL have parameter NCH, 4, number of input channels (2..8).
REQ-002 SHALL have parameter W, 16, signed input sample width (8..16).
REQ-003 SHALL have parameter WOUT, 16, signed output width.
REQ-004 SHALL have parameter GAIN_RST, {NCH{8'h10}}, packed per-channel gain reset values, 4.4 unsigned.
REQ-005 SHALL have parameter PEAK_HOLD, 1024, samples peak stays asserted after last clip.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-008 SHALL have port clk  in  1  system clock.
REQ-009 SHALL have port cen  in  1  sample strobe, one clk wide.
REQ-010 SHALL have port ch_in  in  NCH*W  packed signed samples, channel 0 in LSBs.
REQ-011 SHALL have port ch_en  in  NCH  per-channel enable; 0 forces zero contribution.
REQ-012 SHALL have port gain_we  in  1  gain register write strobe.
REQ-013 SHALL have port gain_sel  in  3  gain register index.
REQ-014 SHALL have port gain_din  in  8  gain value, 4.4 unsigned.
REQ-015 SHALL have port mixed  out  WOUT  signed mixed sample.
REQ-016 SHALL have port sample  out  1  one-cycle pulse when mixed updates.
REQ-017 SHALL have port peak  out  1  clip indicator, held.
REQ-018 SHALL have port overrun  out  1  one-cycle pulse when cen arrives while busy.

Function
REQ-019 SHALL run states IDLE, MAC, DONE.
REQ-020 IDLE + cen: SHALL capture ch_in, ch_en and all gains into shadow registers, clear accumulator, go to MAC with index 0.
REQ-021 MAC: SHALL add one sign-extended ch*gain product per clk, using a single shared multiplier; after index NCH-1, go to DONE.
REQ-022 DONE: SHALL shift accumulator right 4 with sign, saturate to WOUT, register into mixed, pulse sample, return to IDLE.
REQ-023 Latency SHALL be NCH+2 clk from cen to sample.
REQ-024 Accumulator SHALL be W+8+clog2(NCH) bits; no internal overflow is permitted.
REQ-025 Saturation SHALL clamp to +2^(WOUT-1)-1 / -2^(WOUT-1); either clamp SHALL set peak and reload the hold counter with PEAK_HOLD.
REQ-026 Hold counter SHALL decrement on each non-clipping sample; peak deasserts when it reaches 0.
REQ-027 W<WOUT: inputs SHALL be left-aligned (shifted by WOUT-W) before multiplication.
REQ-028 gain_we SHALL update register gain_sel on the next clk; gain_sel>=NCH SHALL be ignored.
REQ-029 Gain writes during MAC SHALL NOT affect the sample in progress; they apply from the next capture.
REQ-030 cen outside IDLE SHALL be dropped and SHALL pulse overrun; mixed SHALL be unchanged.
REQ-031 cen and gain_we in the same clk in IDLE: capture SHALL use the old gain value.
REQ-032 mixed SHALL hold its value between sample pulses.

Reset
REQ-033 Reset SHALL force state IDLE, mixed=0, sample=0, peak=0, overrun=0, hold counter=0, accumulator=0, gains=GAIN_RST.
REQ-034 Reset asserted mid-MAC SHALL abort the sample without a sample pulse; first cen after release starts a clean cycle.

Structure
REQ-035 State encoding, 4.4 gain unity constant (8'h10) and the clog2 helper SHALL live in shared package jtcop_snd_pkg.
REQ-036 Saturation/peak-hold logic SHALL be a sub-module jtcop_sndmix_sat.

Verification
REQ-037 NCH=4, all gains 8'h10, ch_in={16'd100,16'd200,-16'd50,16'd0}, cen -> mixed=250, sample exactly 6 clk after cen.
REQ-038 ch0=16'h7000, ch1=16'h7000, gains 8'h10 -> mixed=16'h7FFF, peak=1; then 1024 zero samples -> peak=0 on the following sample, not before.
REQ-039 gain_we sel=1 din=8'h20 during MAC of sample A -> sample A uses 8'h10; sample B doubles ch1's contribution.
REQ-040 cen pulsed at cycle 2 of MAC -> overrun one-cycle pulse, only one sample pulse, mixed equals first-capture result.
REQ-041 ch_en=4'b0001, ch0=-16'd300, other channels 16'd1000 -> mixed=-300.
REQ-042 rst asserted mid-MAC -> no sample pulse, mixed=0, gains back to GAIN_RST on next read-back via mixing.
